nand_inertial_delay: RTL
========================

Name: nand_inertial_delay

Overview:
- Cycle-based behavioural model of a bank of multi-input NAND gates. Each output transition has its own programmable rise and fall delay, counted in clock ticks.
- Short input pulses are rejected (inertial filtering).
- Optional sense mode restarts the pending delay on any input activity, even when the logical target does not change.
- Used in gate-level study benches as a clocked, delay-annotated NAND stand-in that needs no SDF back-annotation.

Parameters:
- CHANNELS, 4, number of independent NAND gates.
- INPUTS, 2, inputs per gate (≥2).
- CNT_W, 6, width of the delay values and of the per-channel counters.

Ports:
- clk  input  1  rising-edge clock; one tick is one delay unit.
- rst  input  1  asynchronous, active-high reset.
- sense_en  input  1  1 = restart the pending delay on any input bit change.
- rise_dly  input  CNT_W  delay for 0->1 output transitions; 0 is treated as 1.
- fall_dly  input  CNT_W  delay for 1->0 output transitions; 0 is treated as 1.
- in_bus  input  CHANNELS*INPUTS  channel c uses bits [c*INPUTS +: INPUTS]; synchronous to clk.
- out  output  CHANNELS  delayed NAND outputs.
- busy  output  CHANNELS  1 while channel c has a transition pending.
- reject_pulse  output  CHANNELS  one-cycle strobe when a pending transition is cancelled.

Behaviour:
- Reset (asynchronous, active-high): out=all 1, busy=0, reject_pulse=0, counters=0. Each channel's in_prev register resets to 0.
- Per-channel registers:
  - out_q
  - pending (drives busy)
  - pend_val
  - cnt [CNT_W]
  - in_prev [INPUTS]
- Combinational target: tgt = ~&in_c. Effective delay: D = (value==0) ? 1 : value. D is rise_dly when the new value is 1, fall_dly when it is 0.
- At every rising edge, each channel evaluates in this priority order:
  1. Cancel: pending=1 and tgt==out_q. Clear pending and pulse reject_pulse for 1 cycle; out unchanged.
  2. Start: pending=0 and tgt!=out_q. Set pending=1, pend_val=tgt, cnt=D-1. D is latched at this edge; later changes to rise_dly/fall_dly do not affect a pending transition.
  3. Sense restart: pending=1, sense_en=1, in_c!=in_prev. Reload cnt=D-1, using D for pend_val.
  4. Commit: pending=1 and cnt==0. out_q<=pend_val, pending<=0.
  5. Count: pending=1. cnt<=cnt-1.
- in_prev<=in_c at every edge.
- Latency: if the new tgt is first sampled at edge e and held, out changes on edge e+D. This requires D+1 consecutive samples of the new value. A pulse of ≤D samples is rejected.
- reject_pulse is registered and high only on the edge following the cancel decision. It does not block a Start on the next edge.
- Channels are fully independent. No cross-channel state.
- Reset asserted mid-pending: the transition is discarded immediately and out returns to 1.
- Counter never underflows: Commit occurs exactly at cnt==0.

Test Plan:
1. Reset release, rise_dly=30, fall_dly=29, channel 0 inputs set to 11 → out[0] falls exactly 29 edges after first sampling 11; busy high for those 29 cycles.
2. From out[0]=0, input goes to 01 → out[0] rises after 30 edges; reject_pulse stays 0 throughout.
3. Inertial rejection, fall_dly=5: 5-cycle pulse of 11 → out stays 1, reject_pulse[0] pulses once, busy drops. 6-cycle pulse of 11 → out falls at the 5th edge.
4. Sense mode, sense_en=1, out[0]=0, rise_dly=10: input 00 then 10 at edge +4, then 01 at edge +7 → the rise is restarted each time and occurs 10 edges after the last change. With sense_en=0 the rise occurs 10 edges after the first change.
5. rise_dly=0 → out rises 1 edge after the first sample. Changing fall_dly during a pending fall does not alter the commit edge.
6. CHANNELS=4, INPUTS=3, staggered stimulus on all channels with rst asserted mid-pending on channel 2 → independent timing per channel; after reset out=4'b1111, busy=0.

Source files
------------

// File: rtl/nand_inertial_delay.sv
// Bank of clocked multi-input NAND gates with programmable rise/fall delays and
// inertial filtering. A pulse shorter than the effective delay never reaches
// the output. Optional sense mode restarts a pending delay on any input change.
module nand_inertial_delay #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned INPUTS   = 2,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sense_en,
  input  logic [CNT_W-1:0]             rise_dly,
  input  logic [CNT_W-1:0]             fall_dly,
  input  logic [CHANNELS*INPUTS-1:0]   in_bus,
  output logic [CHANNELS-1:0]          out,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          reject_pulse
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Per-channel decision taken at each edge, highest priority first.
  typedef enum logic [2:0] {
    ActHold,
    ActCancel,
    ActStart,
    ActRestart,
    ActCommit,
    ActCount
  } act_e;

  // Counter reload value: effective delay minus one, with a zero delay treated as one.
  function automatic logic [CNT_W-1:0] dly_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CntOne;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [INPUTS-1:0] in_c;
    logic [INPUTS-1:0] in_prev_q, in_prev_d;
    logic              tgt;
    logic              out_q, out_d;
    logic              pend_q, pend_d;
    logic              pend_val_q, pend_val_d;
    logic              rej_q, rej_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    act_e              act;

    assign in_c = in_bus[c*INPUTS +: INPUTS];
    assign tgt  = ~&in_c;

    // Pick the single action for this edge in priority order.
    always_comb begin
      act = ActHold;
      if (pend_q && (tgt == out_q)) begin
        act = ActCancel;
      end else if (!pend_q && (tgt != out_q)) begin
        act = ActStart;
      end else if (pend_q && sense_en && (in_c != in_prev_q)) begin
        act = ActRestart;
      end else if (pend_q && (cnt_q == '0)) begin
        act = ActCommit;
      end else if (pend_q) begin
        act = ActCount;
      end
    end

    // Next-state for the channel registers given the chosen action.
    always_comb begin
      out_d      = out_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      cnt_d      = cnt_q;
      rej_d      = 1'b0;
      in_prev_d  = in_c;
      unique case (act)
        ActCancel: begin
          pend_d = 1'b0;
          rej_d  = 1'b1;
        end
        ActStart: begin
          // The delay is captured into the counter here, so later edits to
          // rise_dly/fall_dly cannot move this commit.
          pend_d     = 1'b1;
          pend_val_d = tgt;
          cnt_d      = tgt ? dly_m1(rise_dly) : dly_m1(fall_dly);
        end
        ActRestart: begin
          cnt_d = pend_val_q ? dly_m1(rise_dly) : dly_m1(fall_dly);
        end
        ActCommit: begin
          out_d  = pend_val_q;
          pend_d = 1'b0;
        end
        ActCount: begin
          cnt_d = cnt_q - CntOne;
        end
        default: ;
      endcase
    end

    // Channel state; reset drops any pending transition and forces the output high.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q      <= 1'b1;
        pend_q     <= 1'b0;
        pend_val_q <= 1'b1;
        cnt_q      <= '0;
        rej_q      <= 1'b0;
        in_prev_q  <= '0;
      end else begin
        out_q      <= out_d;
        pend_q     <= pend_d;
        pend_val_q <= pend_val_d;
        cnt_q      <= cnt_d;
        rej_q      <= rej_d;
        in_prev_q  <= in_prev_d;
      end
    end

    assign out[c]          = out_q;
    assign busy[c]         = pend_q;
    assign reject_pulse[c] = rej_q;
  end

endmodule
